// File: rtl/tone_generator.sv
// tone_generator: glitch-free square-wave tone source with PWM volume gating.
// The half-period is sampled from tone_input only at half-period boundaries.
// Stops are also deferred to boundaries, so every half that starts high runs
// its full length. A free-running carrier gates the high phase to set volume.
module tone_generator #(
  parameter int CNT_WIDTH = 24,
  parameter int PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tone_enable,
  input  logic [CNT_WIDTH-1:0] tone_input,
  input  logic [PWM_WIDTH-1:0] volume,
  output logic                 square_out,
  output logic                 pwm_out,
  output logic                 active
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_period_q;
  logic [CNT_WIDTH-1:0] w_period_nxt;
  logic                 r_square;
  logic                 w_square_nxt;
  logic                 r_active;
  logic                 w_active_nxt;
  logic [PWM_WIDTH-1:0] r_carrier;
  logic                 r_pwm;
  logic                 w_boundary;
  logic                 w_tone_zero;

  // period_q is never 0 while in RUN, so period_q-1 cannot underflow there;
  // in IDLE the compare result is ignored.
  assign w_boundary  = (r_cnt == (r_period_q - CNT_WIDTH'(1)));
  assign w_tone_zero = (tone_input == '0);

  // Next-state and next-output logic for the IDLE/RUN controller.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_period_nxt = r_period_q;
    w_square_nxt = r_square;
    w_active_nxt = r_active;
    case (r_state)
      IDLE: begin
        w_cnt_nxt    = '0;
        w_square_nxt = 1'b0;
        w_active_nxt = 1'b0;
        if (tone_enable && !w_tone_zero) begin
          w_period_nxt = tone_input;
          w_square_nxt = 1'b1;
          w_active_nxt = 1'b1;
          w_state_nxt  = RUN;
        end
      end
      RUN: begin
        if (!tone_enable && !r_square) begin
          // Already in the low half: stopping here cannot truncate a pulse.
          w_cnt_nxt    = '0;
          w_square_nxt = 1'b0;
          w_active_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end else if (w_boundary) begin
          w_cnt_nxt = '0;
          // A pending stop (enable still low) or a zero period wins over the
          // toggle, so the output can only fall at this edge, never rise.
          if (!tone_enable || w_tone_zero) begin
            w_square_nxt = 1'b0;
            w_active_nxt = 1'b0;
            w_state_nxt  = IDLE;
          end else begin
            w_square_nxt = ~r_square;
            w_period_nxt = tone_input;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_cnt_nxt    = '0;
        w_square_nxt = 1'b0;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  // Controller state, half-period counter and registered tone outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_period_q <= '0;
      r_square   <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_period_q <= w_period_nxt;
      r_square   <= w_square_nxt;
      r_active   <= w_active_nxt;
    end
  end

  // Free-running carrier and volume gating of the registered square wave.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carrier <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_carrier <= r_carrier + PWM_WIDTH'(1);
      r_pwm     <= r_square & (r_carrier < volume);
    end
  end

  assign square_out = r_square;
  assign pwm_out    = r_pwm;
  assign active     = r_active;

endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: directed scenarios followed by randomized stimulus,
// all compared each cycle against a countdown-based behavioural model.
module tb_tone_generator;

  localparam int CW = 24;
  localparam int PW = 4;
  localparam int CARRIER_MOD = 1 << PW;

  logic          clk;
  logic          rst;
  logic          en;
  logic [CW-1:0] ti;
  logic [PW-1:0] vol;
  logic          sq;
  logic          pwm;
  logic          act;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: a tone is "running" with a "level", and "remain"
  // counts the cycles left in the current half.
  bit m_run;
  bit m_level;
  bit m_pwm;
  int m_remain;
  int m_carrier;

  tone_generator #(.CNT_WIDTH(CW), .PWM_WIDTH(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_enable(en),
    .tone_input (ti),
    .volume     (vol),
    .square_out (sq),
    .pwm_out    (pwm),
    .active     (act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run     = 1'b0;
    m_level   = 1'b0;
    m_pwm     = 1'b0;
    m_remain  = 0;
    m_carrier = 0;
  endtask

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_pwm     = m_level && (m_carrier < int'(vol));
      m_carrier = (m_carrier + 1) % CARRIER_MOD;
      if (!m_run) begin
        if (en && ti != 0) begin
          m_run    = 1'b1;
          m_level  = 1'b1;
          m_remain = int'(ti);
        end
      end else if (!en && !m_level) begin
        m_run = 1'b0;
      end else if (m_remain == 1) begin
        if (!en || ti == 0) begin
          m_run   = 1'b0;
          m_level = 1'b0;
        end else begin
          m_level  = !m_level;
          m_remain = int'(ti);
        end
      end else begin
        m_remain--;
      end
    end
  endtask

  // Check outputs of the previous edge, then drive inputs for the next one.
  task automatic cycle(input bit r, input bit e, input int t, input int v);
    @(negedge clk);
    check("square_out", sq, m_level);
    check("active", act, m_run);
    check("pwm_out", pwm, m_pwm);
    rst = r;
    en  = e;
    ti  = CW'(t);
    vol = PW'(v);
    model_step();
  endtask

  task automatic run_for(input int n, input bit e, input int t, input int v);
    for (int i = 0; i < n; i++) cycle(1'b0, e, t, v);
  endtask

  initial begin
    int r_t;
    int r_v;
    bit r_e;
    rst = 1'b1;
    en  = 1'b0;
    ti  = '0;
    vol = '0;
    model_reset();

    // Reset state, then a steady ti=3 tone.
    cycle(1'b1, 1'b0, 0, 0);
    cycle(1'b1, 1'b0, 0, 0);
    run_for(20, 1'b1, 3, 8);

    // Period change during the first high half.
    cycle(1'b1, 1'b0, 0, 8);
    cycle(1'b0, 1'b1, 3, 8);
    run_for(24, 1'b1, 5, 8);

    // Enable dropped early in a 10-cycle high half.
    cycle(1'b1, 1'b0, 0, 8);
    cycle(1'b0, 1'b1, 10, 8);
    run_for(20, 1'b0, 10, 8);

    // Enable dropped then re-asserted before the boundary.
    cycle(1'b0, 1'b1, 6, 8);
    run_for(2, 1'b0, 6, 8);
    run_for(20, 1'b1, 6, 8);

    // Zero period keeps the block silent until a real period arrives.
    cycle(1'b1, 1'b0, 0, 8);
    run_for(10, 1'b1, 0, 8);
    run_for(12, 1'b1, 4, 8);

    // Volume gating over a long tone, then volume 0 and full volume.
    cycle(1'b1, 1'b0, 0, 4);
    run_for(250, 1'b1, 100, 4);
    run_for(100, 1'b1, 100, 0);
    run_for(100, 1'b1, 100, 15);

    // Reset mid high half, then a fresh restart.
    cycle(1'b1, 1'b0, 0, 8);
    run_for(3, 1'b1, 7, 8);
    cycle(1'b1, 1'b1, 7, 8);
    run_for(20, 1'b1, 7, 8);

    // Randomized stimulus with sticky enable and period values.
    r_e = 1'b1;
    r_t = 3;
    r_v = 7;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 6) r_e = !r_e;
      if ($urandom_range(0, 99) < 12) r_t = int'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 3) r_v = int'($urandom_range(0, 15));
      cycle(($urandom_range(0, 499) == 0), r_e, r_t, r_v);
    end
    cycle(1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
